// File: rtl/nim_pkg.sv
// nim_pkg: shared state and response encodings for the Nim pile bank
package nim_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} nim_state_t;
    typedef enum logic [1:0] {RESP_OK, RESP_ZERO_TAKE, RESP_OVERDRAW, RESP_BAD_PILE} nim_resp_t;
endpackage

// File: rtl/nim_pile_bank_full_subtractor.sv
// full_subtractor: one-bit borrow subtractor cell, d = a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/nim_pile_bank.sv
// nim_pile_bank: Nim pile registers updated by validated moves through a bit-serial subtractor
module nim_pile_bank
    import nim_pkg::*;
#(
    parameter int N_PILES    = 4,
    parameter int WIDTH      = 4,
    parameter int INIT_COUNT = 5,
    parameter int IDX_W      = $clog2(N_PILES) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [IDX_W-1:0]           req_pile,
    input  logic [WIDTH-1:0]           req_amount,
    output logic                       resp_valid,
    output logic [1:0]                 resp_code,
    output logic [N_PILES*WIDTH-1:0]   piles,
    output logic                       player,
    output logic [WIDTH-1:0]           nim_sum,
    output logic                       game_over,
    output logic                       winner
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    nim_state_t state, state_n;
    nim_resp_t code_q, code_n;
    logic [WIDTH-1:0] pile_r [N_PILES];
    logic [IDX_W-1:0] pile_q;
    logic [WIDTH-1:0] amt_q, op_a, op_b, diff, sel;
    logic [CNT_W-1:0] cnt;
    logic borrow, bad, d, bout;

    full_subtractor u_fs (.a(op_a[0]), .b(op_b[0]), .bin(borrow), .d(d), .bout(bout));

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = (state == IDLE && req_valid) ? SHIFT :
                  (state == SHIFT && cnt == LAST) ? COMMIT :
                  (state == COMMIT) ? IDLE : state;
        sel = '0;
        bad = 1'b1;
        for (int i = 0; i < N_PILES; i++) begin
            if (req_pile == IDX_W'(i)) sel = pile_r[i];
            if (pile_q == IDX_W'(i)) bad = 1'b0;
        end
        code_n = bad ? RESP_BAD_PILE : (amt_q == '0) ? RESP_ZERO_TAKE :
                 borrow ? RESP_OVERDRAW : RESP_OK;
        nim_sum = '0;
        for (int i = 0; i < N_PILES; i++) begin
            nim_sum = nim_sum ^ pile_r[i];
            piles[i*WIDTH +: WIDTH] = pile_r[i];
        end
    end

    assign game_over  = (piles == '0);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == COMMIT);
    assign resp_code  = resp_valid ? code_n : code_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_PILES; i++) pile_r[i] <= WIDTH'(INIT_COUNT);
            player <= 1'b0;
            winner <= 1'b0;
            code_q <= RESP_OK;
            pile_q <= '0;
            amt_q  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                pile_q <= req_pile;
                amt_q  <= req_amount;
                op_a   <= sel;
                op_b   <= req_amount;
                borrow <= 1'b0;
                cnt    <= '0;
            end
            // LSB first: each difference bit enters at the top and walks down
            if (state == SHIFT) begin
                op_a   <= op_a >> 1;
                op_b   <= op_b >> 1;
                diff   <= {d, diff[WIDTH-1:1]};
                borrow <= bout;
                cnt    <= cnt + 1'b1;
            end
            if (state == COMMIT) begin
                code_q <= code_n;
                if (code_n == RESP_OK) begin
                    for (int i = 0; i < N_PILES; i++)
                        if (pile_q == IDX_W'(i)) pile_r[i] <= diff;
                    player <= ~player;
                    winner <= player;
                end
            end
        end
    end
endmodule
